// File: rtl/rf_pkg.sv
// rf_pkg: register-file constants and the write-back request record.
package rf_pkg;
   localparam int RF_DATA_W   = 19;
   localparam int RF_ADDR_W   = 4;
   localparam int RF_NUM_REGS = 16;
   localparam int RF_ZERO_REG = 0;
   typedef struct packed {
      logic                 valid;
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search from ptr wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   localparam int PW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PW-1:0]      idx
);
   logic [PW-1:0] j;
   always_comb begin
      gnt = '0;
      idx = '0;
      j   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = PW'((int'(ptr) + k) % NUM_REQ);
         if (req[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            idx = j;
         end
      end
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter with one staged write, forwarding and starvation flag.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = RF_DATA_W,
   parameter int ADDR_W  = RF_ADDR_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wb_stall,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   input  logic [ADDR_W-1:0]         fwd_addr1,
   input  logic [ADDR_W-1:0]         fwd_addr2,
   output logic                      fwd_hit1,
   output logic                      fwd_hit2,
   output logic [DATA_W-1:0]         fwd_data1,
   output logic [DATA_W-1:0]         fwd_data2,
   output logic                      grant_cnt_ovf
);
   localparam int PW = $clog2(NUM_REQ);
   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_REG);
   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] at_max;
   logic               grant;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic [7:0]         wait_cnt [NUM_REQ];
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req(req_valid),
      .ptr(rr_ptr),
      .gnt(gnt),
      .idx(gnt_idx)
   );
   assign req_ready = (rst_n && !wb_stall) ? gnt : '0;
   assign grant     = |req_ready;
   assign sel_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
   assign sel_data  = req_data[gnt_idx*DATA_W +: DATA_W];
   assign fwd_hit1  = wr_en && (fwd_addr1 == wr_addr) && (fwd_addr1 != ZERO);
   assign fwd_hit2  = wr_en && (fwd_addr2 == wr_addr) && (fwd_addr2 != ZERO);
   assign fwd_data1 = fwd_hit1 ? wr_data : '0;
   assign fwd_data2 = fwd_hit2 ? wr_data : '0;
   // flag rises on the same edge a waiting counter lands on 255
   always_comb begin
      at_max = '0;
      for (int i = 0; i < NUM_REQ; i++)
         at_max[i] = req_valid[i] && !req_ready[i] && (wait_cnt[i] >= 8'd254);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         rr_ptr        <= '0;
         grant_cnt_ovf <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
      end else begin
         wr_en <= grant && (sel_addr != ZERO);
         if (grant) begin
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            rr_ptr  <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
         end
         if (|at_max) grant_cnt_ovf <= 1'b1;
         for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) wait_cnt[i] <= '0;
            else if (req_valid[i] && wait_cnt[i] != 8'hFF) wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: random + directed stimulus, reference model feeds a per-cycle scoreboard.
module tb_rf_wb_arbiter;
   localparam int N = 3, DW = 19, AW = 4;
   localparam logic [DW-1:0] DA = 19'h0AAAA, DB = 19'h0BBBB;
   logic clk = 1'b0, rst_n = 1'b0, wb_stall = 1'b0;
   logic [N-1:0] req_valid = '0, req_ready;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic wr_en, fwd_hit1, fwd_hit2, grant_cnt_ovf;
   logic [AW-1:0] wr_addr, fwd_addr1 = '0, fwd_addr2 = '0;
   logic [DW-1:0] wr_data, fwd_data1, fwd_data2;
   always #5 clk = ~clk;
   rf_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .grant_cnt_ovf(grant_cnt_ovf)
   );
   typedef struct {
      logic en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic ovf;
   } ent_t;
   ent_t sbq[$];
   ent_t st, e;
   logic [N-1:0] pv;
   logic [AW-1:0] pa [N];
   logic [DW-1:0] pd [N];
   logic [AW-1:0] fa1 = '0, fa2 = '0;
   logic [DW-1:0] rf [16];
   int ptr_m, wcnt [N];
   logic ovf_m;
   int total = 0, passed = 0;
   bit mon_on = 0, rand_fwd = 0;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
   endtask
   task automatic model_reset();
      ptr_m = 0;
      st = '{en: 1'b0, addr: '0, data: '0, ovf: 1'b0};
      for (int i = 0; i < N; i++) wcnt[i] = 0;
      ovf_m = 1'b0;
      pv = '0;
      sbq.delete();
   endtask
   // one cycle: drive at negedge, predict the grant and the state staged at the next posedge
   task automatic step(input logic stall);
      int g;
      logic [N-1:0] er;
      @(negedge clk);
      wb_stall = stall;
      req_valid = pv;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = pa[i];
         req_data[i*DW +: DW] = pd[i];
      end
      #1;
      g = -1;
      if (!stall)
         for (int k = 0; k < N; k++)
            if (g < 0 && pv[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      for (int i = 0; i < N; i++) begin
         if (i == g) wcnt[i] = 0;
         else if (pv[i] && wcnt[i] < 255) wcnt[i]++;
         if (wcnt[i] == 255) ovf_m = 1'b1;
      end
      st.en = 1'b0;
      if (g >= 0) begin
         st.en = (pa[g] != 0);
         st.addr = pa[g];
         st.data = pd[g];
         ptr_m = (g + 1) % N;
         pv[g] = 1'b0;
      end
      st.ovf = ovf_m;
      sbq.push_back(st);
      fwd_addr1 = rand_fwd ? ($urandom_range(0, 1) != 0 ? st.addr : 4'($urandom)) : fa1;
      fwd_addr2 = rand_fwd ? ($urandom_range(0, 1) != 0 ? st.addr : 4'($urandom)) : fa2;
   endtask
   initial forever begin
      @(posedge clk);
      #1;
      if (mon_on && sbq.size() > 0) begin
         logic h1, h2;
         e = sbq.pop_front();
         h1 = e.en && fwd_addr1 == e.addr && fwd_addr1 != 0;
         h2 = e.en && fwd_addr2 == e.addr && fwd_addr2 != 0;
         chk("wr_en", 32'(wr_en), 32'(e.en));
         chk("wr_addr", 32'(wr_addr), 32'(e.addr));
         chk("wr_data", 32'(wr_data), 32'(e.data));
         chk("ovf", 32'(grant_cnt_ovf), 32'(e.ovf));
         chk("fwd_hit1", 32'(fwd_hit1), 32'(h1));
         chk("fwd_hit2", 32'(fwd_hit2), 32'(h2));
         chk("fwd_data1", 32'(fwd_data1), h1 ? 32'(e.data) : 32'd0);
         chk("fwd_data2", 32'(fwd_data2), h2 ? 32'(e.data) : 32'd0);
      end
      if (wr_en) rf[wr_addr] = wr_data;
   end
   task automatic chk_reset();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_ovf", 32'(grant_cnt_ovf), 32'd0);
   endtask
   task automatic set_all3();
      pv = 3'b111;
      pa[0] = 4'd1; pd[0] = 19'h00011;
      pa[1] = 4'd2; pd[1] = 19'h00022;
      pa[2] = 4'd3; pd[2] = 19'h00033;
   endtask
   initial begin
      model_reset();
      for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; end
      repeat (2) @(negedge clk);
      chk_reset();
      rst_n = 1'b1;
      mon_on = 1;
      set_all3();
      step(1'b0);
      step(1'b0);
      #2;
      mon_on = 0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;
      mon_on = 1;
      repeat (2) step(1'b0);
      repeat (6) begin set_all3(); step(1'b0); end
      step(1'b0);
      pv = 3'b010; pa[1] = 4'd0; pd[1] = 19'h7FFFF; fa1 = 4'd0; fa2 = 4'd0;
      step(1'b0);
      pv = 3'b100; pa[2] = 4'd5; pd[2] = 19'h12345; fa1 = 4'd5; fa2 = 4'd6;
      step(1'b0);
      step(1'b0);
      rand_fwd = 1;
      repeat (400) begin
         for (int i = 0; i < N; i++)
            if (!pv[i] && $urandom_range(0, 3) != 0) begin
               pv[i] = 1'b1;
               pa[i] = 4'($urandom);
               pd[i] = 19'($urandom);
            end
         step($urandom_range(0, 9) == 0);
      end
      for (int k = 0; k < N && pv != 0; k++) step(1'b0);
      rand_fwd = 0;
      pv = 3'b010; pa[1] = 4'd1; pd[1] = 19'h00001;
      step(1'b0);
      pv = 3'b101; pa[0] = 4'd7; pd[0] = DA; pa[2] = 4'd7; pd[2] = DB;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      pv = 3'b001; pa[0] = 4'd9; pd[0] = 19'h00099;
      step(1'b0);
      repeat (300) begin
         pv[0] = 1'b1; pa[0] = 4'd4; pd[0] = 19'h00044;
         step(1'b1);
      end
      chk("ovf_after_stall", 32'(grant_cnt_ovf), 32'd1);
      step(1'b0);
      repeat (2) step(1'b0);
      repeat (2) @(posedge clk);
      #2;
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      chk("rf7_final", 32'(rf[7]), 32'(DA));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Round-robin write-back arbiter for the 16 x 19-bit register file's single write port.
- Up to NUM_REQ execution units (ALU, load unit, multiplier) present write requests over valid/ready.
- One winner per cycle is registered into a staging slot that drives the register-file write port.
- Two forwarding lookups expose the staged, not-yet-committed write to the read stage. Writes to r0 are discarded.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
DATA_W, 19, register data width
ADDR_W, 4, register address width (16 registers)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wb_stall  input  1  blocks new grants while high
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data, same packing
req_ready  output  NUM_REQ  one-hot grant, combinational
wr_en  output  1  register-file write enable (registered)
wr_addr  output  ADDR_W  register-file write address (registered)
wr_data  output  DATA_W  register-file write data (registered)
fwd_addr1, fwd_addr2  input  ADDR_W  read addresses to check against the staged write
fwd_hit1, fwd_hit2  output  1  staged write matches the address, combinational
fwd_data1, fwd_data2  output  DATA_W  staged data when hit, else 0
grant_cnt_ovf  output  1  sticky flag: some requester waited >= 255 cycles

Behaviour:
- Reset (rst_n low, asynchronous): wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0, grant_cnt_ovf=0, all wait counters=0.
  - req_ready is 0 during reset.
  - Reset mid-transfer drops the staged write; it never reaches the register file.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i] in the same cycle.
  - A requester holds valid, addr and data stable until ready.
  - Ready never depends on a requester dropping valid.
- Arbitration (combinational):
  - Search starts at index rr_ptr and wraps modulo NUM_REQ; the first valid requester wins.
  - req_ready is one-hot or zero. It is all-zero when wb_stall=1 or no requester is valid.
- Pointer update: on a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Staging, 1-cycle latency:
  - On a grant, at the next rising edge wr_en <= (addr != 0), wr_addr <= addr, wr_data <= data.
  - Without a grant, wr_en <= 0. wr_addr and wr_data hold their previous values.
  - The register file commits at the following edge, so a granted value is architecturally visible 2 edges after its handshake.
- r0 writes: the requester is still granted and acknowledged, but wr_en stays 0.
- Stall: wb_stall blocks new grants only. A write already staged still commits.
- Throughput: one write per cycle sustained. No bubble between back-to-back grants.
- Forwarding:
  - fwd_hitN = wr_en & (fwd_addrN == wr_addr) & (fwd_addrN != 0).
  - fwd_dataN = wr_data on a hit, else 0.
  - Forwarding covers only the single staged entry.
- Same-address requests in one cycle: only one is granted. Order follows round-robin, and later-granted data overwrites earlier. No merging.
- Starvation monitor:
  - Each requester has an 8-bit wait counter: increments while valid & !ready, clears on grant, saturates at 255.
  - Reaching 255 sets grant_cnt_ovf, which is cleared only by reset.
  - Round-robin bounds the wait to NUM_REQ-1 cycles absent stall, so the flag indicates a stall or protocol fault.

Decomposition:
- Shared package rf_pkg holds:
  - constants RF_DATA_W=19, RF_ADDR_W=4, RF_NUM_REGS=16, RF_ZERO_REG=0;
  - a wb_req struct {valid, addr, data}.
  The register file and this block both use the package.
- One natural sub-module: rr_arbiter (parameterised NUM_REQ).
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational, reusable for the future read-port arbiter.
- Staging, forwarding and the counters stay in rf_wb_arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req_valid=3'b111 -> all outputs 0 immediately, no wr_en after release until a new grant.
- All three requesters valid continuously (addrs 1,2,3; data 19'h00011, 19'h00022, 19'h00033) from rr_ptr=0 -> grants 0,1,2,0... each cycle; wr_addr sequence 1,2,3 one cycle after each grant, wr_en continuously 1.
- Requester 1 writes addr 0, data 19'h7FFFF -> req_ready[1]=1, next cycle wr_en=0, fwd_hit1=0 for fwd_addr1=0.
- Requester 2 writes addr 5 data 19'h12345, fwd_addr1=5 in the staging cycle -> fwd_hit1=1, fwd_data1=19'h12345; fwd_addr2=6 -> fwd_hit2=0, fwd_data2=0.
- wb_stall=1 for 300 cycles with requester 0 valid -> no grants, already-staged write still asserts wr_en once, grant_cnt_ovf=1 after 255 waiting cycles; release stall -> requester 0 granted next cycle.
- Requesters 0 and 2 both valid for addr 7 (data A, B), rr_ptr=2 -> requester 2 granted first then 0; register 7 ends with data A.
